// File: rtl/tis_timer_pkg.sv
// ---------------------------------------------------------------------------
// tis_timer_pkg
// Shared constants for the TIS multi-channel interval timer: register
// offsets within a channel slot, control/status bit positions and the
// default reload period used at reset.
// ---------------------------------------------------------------------------
package tis_timer_pkg;

    // Register offsets inside one channel's eight-word window
    localparam logic [2:0] REG_STATUS   = 3'd0;
    localparam logic [2:0] REG_CONTROL  = 3'd1;
    localparam logic [2:0] REG_PERIOD_L = 3'd2;
    localparam logic [2:0] REG_PERIOD_H = 3'd3;
    localparam logic [2:0] REG_SNAP_L   = 3'd4;
    localparam logic [2:0] REG_SNAP_H   = 3'd5;
    localparam logic [2:0] REG_PRESCALE = 3'd6;
    localparam logic [2:0] REG_PENDING  = 3'd7;

    // Status register bit positions
    localparam int STAT_TO  = 0;
    localparam int STAT_RUN = 1;

    // Control register bit positions
    localparam int CTRL_ITO   = 0;
    localparam int CTRL_CONT  = 1;
    localparam int CTRL_START = 2;
    localparam int CTRL_STOP  = 3;

    // Reload value of every channel's period and counter after reset
    localparam int unsigned DEFAULT_RESET_PERIOD = 49999;

endpackage

// File: rtl/tis_timer_channel.sv
// ---------------------------------------------------------------------------
// tis_timer_channel
// One timer channel: period, prescaler, down-counter, TO/RUN flags,
// control bits and counter snapshot.
//
// Ports:
//   clk, reset_n        clock, asynchronous active-low reset
//   wr_status           write strobe, status register (clears TO)
//   wr_control          write strobe, control register (START/STOP act here)
//   wr_period_l/_h      write strobes, period halves (force a reload)
//   wr_snap             write strobe, captures the live counter
//   wr_prescale         write strobe, prescale register
//   wr_data[15:0]       bus write data
//   rd_*[15:0]          read view of each register, zero-extended
//   to                  timeout flag
//   irq                 channel interrupt, TO & ITO
// ---------------------------------------------------------------------------
module tis_timer_channel
    import tis_timer_pkg::*;
#(
    parameter int          CNT_W        = 32,
    parameter int          PRE_W        = 8,
    parameter int unsigned RESET_PERIOD = DEFAULT_RESET_PERIOD
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        wr_status,
    input  logic        wr_control,
    input  logic        wr_period_l,
    input  logic        wr_period_h,
    input  logic        wr_snap,
    input  logic        wr_prescale,
    input  logic [15:0] wr_data,
    output logic [15:0] rd_status,
    output logic [15:0] rd_control,
    output logic [15:0] rd_period_l,
    output logic [15:0] rd_period_h,
    output logic [15:0] rd_snap_l,
    output logic [15:0] rd_snap_h,
    output logic [15:0] rd_prescale,
    output logic        to,
    output logic        irq
);

    localparam logic [CNT_W-1:0] RESET_CNT = CNT_W'(RESET_PERIOD);

    logic [CNT_W-1:0] period;
    logic [CNT_W-1:0] counter;
    logic [CNT_W-1:0] snap;
    logic [PRE_W-1:0] prescale;
    logic [PRE_W-1:0] pre_cnt;
    logic [3:0]       ctrl;
    logic             run;
    logic             reload_pending;

    logic tick;
    logic timeout;
    logic start_req;
    logic stop_req;

    // A tick fires when the prescale count has run down to zero. The
    // reload cycle that follows a period write takes priority over any
    // tick, so no timeout can be reported from a stale count.
    assign tick      = run && (pre_cnt == '0);
    assign timeout   = tick && (counter == '0) && !reload_pending;
    assign start_req = wr_control && wr_data[CTRL_START];
    assign stop_req  = wr_control && wr_data[CTRL_STOP];

    // Register writes, prescaler and counter. A period write only updates
    // the period register; the counter reloads one cycle later from the
    // full period, so the halves can be written in either order.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            period         <= RESET_CNT;
            counter        <= RESET_CNT;
            snap           <= '0;
            prescale       <= '0;
            pre_cnt        <= '0;
            ctrl           <= '0;
            reload_pending <= 1'b0;
        end else begin
            if (wr_period_l) period[15:0] <= wr_data;
            if (wr_period_h) period[CNT_W-1:16] <= wr_data[CNT_W-17:0];
            reload_pending <= wr_period_l || wr_period_h;
            if (wr_prescale) prescale <= wr_data[PRE_W-1:0];
            if (wr_control) ctrl <= wr_data[3:0];
            if (wr_snap) snap <= counter;

            if (reload_pending) begin
                counter <= period;
                pre_cnt <= prescale;
            end else if (run) begin
                if (pre_cnt == '0) begin
                    pre_cnt <= prescale;
                    counter <= (counter == '0) ? period : counter - 1'b1;
                end else begin
                    pre_cnt <= pre_cnt - 1'b1;
                end
            end
        end
    end

    // RUN and TO flags. START beats STOP, the forced reload and a one-shot
    // expiry; a timeout beats a simultaneous status write so no event is
    // lost.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            run <= 1'b0;
            to  <= 1'b0;
        end else begin
            if (start_req) begin
                run <= 1'b1;
            end else if (reload_pending || stop_req) begin
                run <= 1'b0;
            end else if (timeout && !ctrl[CTRL_CONT]) begin
                run <= 1'b0;
            end

            if (timeout) begin
                to <= 1'b1;
            end else if (wr_status) begin
                to <= 1'b0;
            end
        end
    end

    // Zero-extended read views of every register
    always_comb begin
        rd_status           = '0;
        rd_status[STAT_TO]  = to;
        rd_status[STAT_RUN] = run;
        rd_control          = {12'b0, ctrl};
        rd_period_l         = period[15:0];
        rd_period_h         = 16'(period[CNT_W-1:16]);
        rd_snap_l           = snap[15:0];
        rd_snap_h           = 16'(snap[CNT_W-1:16]);
        rd_prescale         = 16'(prescale);
    end

    assign irq = to && ctrl[CTRL_ITO];

endmodule

// File: rtl/tis_multi_timer.sv
// ---------------------------------------------------------------------------
// tis_multi_timer
// Multi-channel interval timer on an Avalon-MM slave. The address is
// {channel index, register offset}; indices at or above NUM_CH read as 0
// and ignore writes. Read data is registered every cycle (no wait states).
//
// Ports:
//   clk, reset_n      clock, asynchronous active-low reset
//   address           {channel, offset[2:0]}
//   chipselect        slave select
//   write_n           active-low write strobe
//   writedata[15:0]   write data
//   readdata[15:0]    registered read data
//   irq               OR of all channel interrupts
//   irq_vec           per-channel interrupt (TO & ITO)
// ---------------------------------------------------------------------------
module tis_multi_timer
    import tis_timer_pkg::*;
#(
    parameter int          NUM_CH       = 4,
    parameter int          CNT_W        = 32,
    parameter int          PRE_W        = 8,
    parameter int unsigned RESET_PERIOD = DEFAULT_RESET_PERIOD,
    parameter int          ADDR_W       = $clog2(NUM_CH) + 3
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [ADDR_W-1:0] address,
    input  logic              chipselect,
    input  logic              write_n,
    input  logic [15:0]       writedata,
    output logic [15:0]       readdata,
    output logic              irq,
    output logic [NUM_CH-1:0] irq_vec
);

    logic [31:0]       ch_num;
    logic [2:0]        reg_off;
    logic              in_range;
    logic              wr_strobe;
    logic [NUM_CH-1:0] to_vec;
    logic [15:0]       pending;
    logic [15:0]       rd_mux;

    logic [15:0] rd_status   [NUM_CH];
    logic [15:0] rd_control  [NUM_CH];
    logic [15:0] rd_period_l [NUM_CH];
    logic [15:0] rd_period_h [NUM_CH];
    logic [15:0] rd_snap_l   [NUM_CH];
    logic [15:0] rd_snap_h   [NUM_CH];
    logic [15:0] rd_prescale [NUM_CH];

    // The channel field is widened to 32 bits so that it can be compared
    // against NUM_CH even when NUM_CH is not a power of two.
    assign ch_num    = 32'(address >> 3);
    assign reg_off   = address[2:0];
    assign in_range  = ch_num < 32'(NUM_CH);
    assign wr_strobe = chipselect && !write_n;
    assign pending   = 16'(to_vec);

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        logic sel;
        assign sel = wr_strobe && in_range && (ch_num == 32'(i));

        tis_timer_channel #(
            .CNT_W       (CNT_W),
            .PRE_W       (PRE_W),
            .RESET_PERIOD(RESET_PERIOD)
        ) u_channel (
            .clk        (clk),
            .reset_n    (reset_n),
            .wr_status  (sel && (reg_off == REG_STATUS)),
            .wr_control (sel && (reg_off == REG_CONTROL)),
            .wr_period_l(sel && (reg_off == REG_PERIOD_L)),
            .wr_period_h(sel && (reg_off == REG_PERIOD_H)),
            .wr_snap    (sel && ((reg_off == REG_SNAP_L) || (reg_off == REG_SNAP_H))),
            .wr_prescale(sel && (reg_off == REG_PRESCALE)),
            .wr_data    (writedata),
            .rd_status  (rd_status[i]),
            .rd_control (rd_control[i]),
            .rd_period_l(rd_period_l[i]),
            .rd_period_h(rd_period_h[i]),
            .rd_snap_l  (rd_snap_l[i]),
            .rd_snap_h  (rd_snap_h[i]),
            .rd_prescale(rd_prescale[i]),
            .to         (to_vec[i]),
            .irq        (irq_vec[i])
        );
    end

    // Read mux: select the addressed channel and offset. The pending word
    // is the same in every channel slot.
    always_comb begin
        rd_mux = '0;
        if (in_range) begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (ch_num == 32'(i)) begin
                    case (reg_off)
                        REG_STATUS:   rd_mux = rd_status[i];
                        REG_CONTROL:  rd_mux = rd_control[i];
                        REG_PERIOD_L: rd_mux = rd_period_l[i];
                        REG_PERIOD_H: rd_mux = rd_period_h[i];
                        REG_SNAP_L:   rd_mux = rd_snap_l[i];
                        REG_SNAP_H:   rd_mux = rd_snap_h[i];
                        REG_PRESCALE: rd_mux = rd_prescale[i];
                        REG_PENDING:  rd_mux = pending;
                        default:      rd_mux = '0;
                    endcase
                end
            end
        end
    end

    // Read data is registered every cycle, giving one cycle of latency
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            readdata <= '0;
        end else begin
            readdata <= rd_mux;
        end
    end

    assign irq = |irq_vec;

endmodule
